l1_mem_arb: RTL and testbench
=============================

Name: l1_mem_arb

Overview:
- Two-port arbiter and sequencer in front of the single-port L1 data/tag memory wrapper.
- Shares the memory between the core lookup port (port A) and the L2 refill port (port B).
- Holds off all traffic until the memory's self-initialisation reports ready.
- Routes the one-cycle-latency read data back to whichever port issued the read.

Parameters:
WIDTH, 32, data width of memory word
DEPTH, 1024, memory depth in words; address width AW = $clog2(DEPTH)
STARVE_LIMIT, 4, consecutive cycles port A may be denied before it gets forced priority (1..15)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
A_REQ  in  1  core request, held until A_GNT
A_WE  in  1  core write (1) / read (0)
A_ADDR  in  AW  core address
A_WDATA  in  WIDTH  core write data
A_GNT  out  1  core request accepted this cycle
A_RVALID  out  1  core read data valid
A_RDATA  out  WIDTH  core read data
B_REQ  in  1  refill request, held until B_GNT
B_WE  in  1  refill write / read
B_ADDR  in  AW  refill address
B_WDATA  in  WIDTH  refill write data
B_GNT  out  1  refill request accepted
B_RVALID  out  1  refill read data valid
B_RDATA  out  WIDTH  refill read data
MEM_EN  out  1  memory enable
MEM_WE  out  1  memory write enable
MEM_ADDR  out  AW  memory address
MEM_WDATA  out  WIDTH  memory write data
MEM_RDATA  in  WIDTH  memory read data, valid the cycle after an enabled read
MEM_READY  in  1  memory initialisation complete

Behaviour:
- Reset (RST_N low, asynchronous) clears:
  - state <= INIT, starve_cnt <= 0, rd_owner <= NONE.
  - A_RVALID = B_RVALID = 0.
- Combinational outputs with no request present:
  - A_GNT = B_GNT = MEM_EN = MEM_WE = 0.
  - MEM_ADDR = 0, MEM_WDATA = 0.
- State INIT:
  - No grants; MEM_EN = 0.
  - Goes to RUN on the first cycle MEM_READY = 1 (registered), so the earliest grant is the cycle after ready rises.
- State RUN:
  - Stays in RUN until reset; MEM_READY is ignored once in RUN.
- Grants (RUN only) are combinational in the request cycle, at most one per cycle:
  - Only B_REQ: B_GNT = 1.
  - Only A_REQ: A_GNT = 1.
  - Both requesting, starve_cnt < STARVE_LIMIT: B wins.
  - Both requesting, starve_cnt == STARVE_LIMIT: A wins.
- Memory drive:
  - MEM_EN = A_GNT | B_GNT.
  - MEM_WE, MEM_ADDR and MEM_WDATA are muxed from the granted port; all are 0 when nothing is granted.
- starve_cnt update:
  - Increments (saturating at STARVE_LIMIT) each cycle A_REQ = 1 and A_GNT = 0.
  - Clears to 0 on A_GNT, or when A_REQ = 0.
- Read return:
  - A granted read (WE = 0) sets rd_owner to that port for the next cycle.
  - Next cycle: the owner's RVALID = 1 and its RDATA = MEM_RDATA.
  - The non-owner's RDATA is 0 and its RVALID is 0.
  - Writes generate no RVALID.
- Back-to-back reads are sustained at 1 per cycle; a grant and the previous read's RVALID may coincide.
- Requesters must hold REQ, WE, ADDR and WDATA stable until GNT. Dropping REQ before GNT is legal and produces no access.
- Reset mid-operation: a pending RVALID is lost and the block returns to INIT.

Optional Feature:
- Macro L1_MEM_ARB_STAT_EN.
- When defined:
  - Adds output port STAT_CONFLICT [15:0]: counts cycles in RUN with A_REQ & B_REQ, saturating at 16'hFFFF.
  - Adds output port STAT_FORCED [15:0]: counts grants to A caused by the starvation rule, saturating.
  - Both counters are cleared by reset.
- When undefined: the ports and counters are absent, and arbitration behaviour is identical.

Decomposition:
- Package l1_cache_pkg holds:
  - typedef enum logic {ARB_INIT, ARB_RUN} arb_state_t
  - typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} rd_owner_t
  - Default constant L1_STARVE_LIMIT = 4.
- One natural sub-module, l1_arb_starve_cnt: the saturating starvation counter with a force_a output. The rest stays flat.

Test Plan:
- Init hold: hold MEM_READY = 0 for 1023 cycles with A_REQ = 1 -> no A_GNT and MEM_EN = 0 throughout; A_GNT first asserted the cycle after MEM_READY = 1.
- Single read: A read at addr 0x10 with MEM_RDATA = 0xDEADBEEF returned the next cycle -> A_RVALID = 1 for one cycle, A_RDATA = 0xDEADBEEF, B_RVALID = 0.
- Refill write priority: A read 0x20 and B write 0x20 = 0x12345678 requested together -> B_GNT first, with MEM_WE = 1 and MEM_WDATA = 0x12345678; A_GNT the following cycle.
- Starvation: B_REQ held continuously, A_REQ asserted at cycle t -> B granted on cycles t..t+3 and A_GNT at t+4 (STARVE_LIMIT = 4); starve_cnt then 0 and B granted again at t+5.
- Back-to-back reads: alternating A and B reads on 4 consecutive cycles -> RVALIDs alternate A, B, A, B one cycle later, each carrying its own MEM_RDATA.
- Reset mid-read: RST_N asserted low in the cycle after an A read grant -> A_RVALID = 0 immediately, state is INIT, and no grant until MEM_READY is seen again.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and defaults for the L1 memory arbiter slice.
package l1_cache_pkg;

  typedef enum logic {ARB_INIT, ARB_RUN} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} rd_owner_t;

  localparam int L1_STARVE_LIMIT = 4;

endpackage

// File: rtl/l1_arb_starve_cnt.sv
// Saturating count of consecutive cycles the core port has been denied;
// force_a_o raises once the count reaches LIMIT.
module l1_arb_starve_cnt
  import l1_cache_pkg::*;
#(
  parameter int LIMIT = L1_STARVE_LIMIT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic a_req_i,
  input  logic a_gnt_i,
  output logic force_a_o
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!a_req_i || a_gnt_i)
      cnt_d = '0;
    else if (cnt_q != LIM)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign force_a_o = (cnt_q == LIM);

endmodule

// File: rtl/l1_mem_arb.sv
// Two-port arbiter in front of the single-port L1 memory: refill (B) has
// priority unless the core (A) is starved. Optional stats: L1_MEM_ARB_STAT_EN.
module l1_mem_arb
  import l1_cache_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int STARVE_LIMIT = L1_STARVE_LIMIT,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A_REQ,
  input  logic             A_WE,
  input  logic [AW-1:0]    A_ADDR,
  input  logic [WIDTH-1:0] A_WDATA,
  output logic             A_GNT,
  output logic             A_RVALID,
  output logic [WIDTH-1:0] A_RDATA,
  input  logic             B_REQ,
  input  logic             B_WE,
  input  logic [AW-1:0]    B_ADDR,
  input  logic [WIDTH-1:0] B_WDATA,
  output logic             B_GNT,
  output logic             B_RVALID,
  output logic [WIDTH-1:0] B_RDATA,
  output logic             MEM_EN,
  output logic             MEM_WE,
  output logic [AW-1:0]    MEM_ADDR,
  output logic [WIDTH-1:0] MEM_WDATA,
  input  logic [WIDTH-1:0] MEM_RDATA,
  input  logic             MEM_READY
`ifdef L1_MEM_ARB_STAT_EN
  ,
  output logic [15:0]      STAT_CONFLICT,
  output logic [15:0]      STAT_FORCED
`endif
);

  arb_state_t state_q, state_d;
  rd_owner_t  owner_q, owner_d;
  logic       force_a;

  l1_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .a_req_i  (A_REQ),
    .a_gnt_i  (A_GNT),
    .force_a_o(force_a)
  );

  always_comb begin
    state_d = state_q;
    A_GNT   = 1'b0;
    B_GNT   = 1'b0;
    unique case (state_q)
      ARB_INIT: if (MEM_READY) state_d = ARB_RUN;
      ARB_RUN: begin
        A_GNT = A_REQ & (~B_REQ | force_a);
        B_GNT = B_REQ & ~A_GNT;
      end
    endcase

    MEM_EN    = A_GNT | B_GNT;
    MEM_WE    = (A_GNT & A_WE) | (B_GNT & B_WE);
    MEM_ADDR  = A_GNT ? A_ADDR  : (B_GNT ? B_ADDR  : '0);
    MEM_WDATA = A_GNT ? A_WDATA : (B_GNT ? B_WDATA : '0);

    // Owner of next cycle's MEM_RDATA.
    owner_d = OWN_NONE;
    if (A_GNT && !A_WE)      owner_d = OWN_A;
    else if (B_GNT && !B_WE) owner_d = OWN_B;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB_INIT;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign A_RVALID = (owner_q == OWN_A);
  assign B_RVALID = (owner_q == OWN_B);
  assign A_RDATA  = A_RVALID ? MEM_RDATA : '0;
  assign B_RDATA  = B_RVALID ? MEM_RDATA : '0;

`ifdef L1_MEM_ARB_STAT_EN
  logic [15:0] conflict_q, forced_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      if (state_q == ARB_RUN && A_REQ && B_REQ && conflict_q != 16'hFFFF)
        conflict_q <= conflict_q + 16'd1;
      if (A_GNT && B_REQ && force_a && forced_q != 16'hFFFF)
        forced_q <= forced_q + 16'd1;
    end
  end

  assign STAT_CONFLICT = conflict_q;
  assign STAT_FORCED   = forced_q;
`endif

endmodule

// File: tb/tb_l1_mem_arb.sv
// Randomized + directed bench for l1_mem_arb against a cycle-level reference model.
module tb_l1_mem_arb;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LIMIT = 4;

  logic             CLK = 1'b0, RST_N = 1'b0;
  logic             A_REQ = 0, A_WE = 0, B_REQ = 0, B_WE = 0, MEM_READY = 0;
  logic [AW-1:0]    A_ADDR = '0, B_ADDR = '0;
  logic [WIDTH-1:0] A_WDATA = '0, B_WDATA = '0;
  logic             A_GNT, A_RVALID, B_GNT, B_RVALID, MEM_EN, MEM_WE;
  logic [WIDTH-1:0] A_RDATA, B_RDATA, MEM_WDATA;
  logic [WIDTH-1:0] MEM_RDATA = '0;
  logic [AW-1:0]    MEM_ADDR;
`ifdef L1_MEM_ARB_STAT_EN
  logic [15:0]      STAT_CONFLICT, STAT_FORCED;
`endif

  l1_mem_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY)
`ifdef L1_MEM_ARB_STAT_EN
    , .STAT_CONFLICT(STAT_CONFLICT), .STAT_FORCED(STAT_FORCED)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port memory behind the arbiter.
  logic [WIDTH-1:0] tmem [DEPTH];
  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_WE) tmem[MEM_ADDR] <= MEM_WDATA;
      else        MEM_RDATA <= tmem[MEM_ADDR];
    end
  end

  int errs = 0, checks = 0;

  // Reference model state
  bit               m_run = 0;
  int               m_starve = 0;
  int               m_own = 0;     // 0 none, 1 A, 2 B
  logic [WIDTH-1:0] m_rd = '0;
  logic [WIDTH-1:0] mdl_mem [DEPTH];
  bit               m_ega, m_egb;

  // Observations of the last step, for directed checks
  logic             o_agnt, o_bgnt, o_mwe, o_arv, o_brv;
  logic [WIDTH-1:0] o_mwd, o_ard, o_brd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad,
                      input bit br, input bit bw, input logic [AW-1:0] ba, input logic [WIDTH-1:0] bd,
                      input bit rdy);
    bit ga, gb;
    @(negedge CLK);
    A_REQ = ar; A_WE = aw; A_ADDR = aa; A_WDATA = ad;
    B_REQ = br; B_WE = bw; B_ADDR = ba; B_WDATA = bd;
    MEM_READY = rdy;
    #1;
    ga = 0; gb = 0;
    if (m_run) begin
      if (ar && (!br || m_starve >= LIMIT)) ga = 1;
      else if (br) gb = 1;
    end
    chk("a_gnt", A_GNT, ga);
    chk("b_gnt", B_GNT, gb);
    chk("mem_en", MEM_EN, ga | gb);
    chk("mem_we", MEM_WE, ga ? aw : (gb ? bw : 1'b0));
    chk("mem_addr", MEM_ADDR, ga ? aa : (gb ? ba : '0));
    chk("mem_wdata", MEM_WDATA, ga ? ad : (gb ? bd : '0));
    chk("a_rvalid", A_RVALID, m_own == 1);
    chk("a_rdata", A_RDATA, (m_own == 1) ? m_rd : '0);
    chk("b_rvalid", B_RVALID, m_own == 2);
    chk("b_rdata", B_RDATA, (m_own == 2) ? m_rd : '0);
    o_agnt = A_GNT; o_bgnt = B_GNT; o_mwe = MEM_WE; o_mwd = MEM_WDATA;
    o_arv = A_RVALID; o_ard = A_RDATA; o_brv = B_RVALID; o_brd = B_RDATA;
    // advance model across the coming edge
    m_own = 0;
    if (ga && !aw)      begin m_own = 1; m_rd = mdl_mem[aa]; end
    else if (gb && !bw) begin m_own = 2; m_rd = mdl_mem[ba]; end
    if (ga && aw) mdl_mem[aa] = ad;
    if (gb && bw) mdl_mem[ba] = bd;
    if (ar && !ga) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else           m_starve = 0;
    if (rdy) m_run = 1;
    m_ega = ga; m_egb = gb;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, '0, '0, 0, 0, '0, '0, rdy);
  endtask

  initial begin
    bit               pa, paw, pb, pbw;
    logic [AW-1:0]    paa, pba;
    logic [WIDTH-1:0] pad, pbd;
    for (int i = 0; i < DEPTH; i++) begin tmem[i] = '0; mdl_mem[i] = '0; end

    // reset state
    #12;
    chk("rst_a_rvalid", A_RVALID, 0);
    chk("rst_b_rvalid", B_RVALID, 0);
    chk("rst_mem_en", MEM_EN, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    @(negedge CLK); RST_N = 1'b1;

    // init hold: core request waits for ready
    for (int i = 0; i < 1023; i++) step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
    step(1, 0, 10'h010, '0, 0, 0, '0, '0, 1);
    chk("init_no_gnt_on_ready", o_agnt, 0);
    step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
    chk("init_first_gnt", o_agnt, 1);
    idle(0);

    // single read returning a known word
    step(0, 0, '0, '0, 1, 1, 10'h010, 32'hDEADBEEF, 0);
    step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
    idle(0);
    chk("rd_a_rvalid", o_arv, 1);
    chk("rd_a_rdata", o_ard, 32'hDEADBEEF);
    chk("rd_b_rvalid", o_brv, 0);
    idle(0);
    chk("rd_a_rvalid_one_cycle", o_arv, 0);

    // refill write beats core read to the same address
    step(1, 0, 10'h020, '0, 1, 1, 10'h020, 32'h12345678, 0);
    chk("prio_b_gnt", o_bgnt, 1);
    chk("prio_mem_we", o_mwe, 1);
    chk("prio_wdata", o_mwd, 32'h12345678);
    step(1, 0, 10'h020, '0, 0, 0, '0, '0, 0);
    chk("prio_a_gnt_next", o_agnt, 1);
    idle(0);
    chk("prio_a_rdata", o_ard, 32'h12345678);

    // starvation: B held, A forced in after LIMIT denials
    for (int k = 0; k < 6; k++) begin
      step(k <= 4, 0, 10'h030, '0, 1, 0, 10'(k), '0, 0);
      if (k < 4)       chk("starve_b_gnt", o_bgnt, 1);
      else if (k == 4) chk("starve_a_forced", o_agnt, 1);
      else             chk("starve_b_again", o_bgnt, 1);
    end
    idle(0);

    // back-to-back alternating reads
    for (int k = 0; k < 4; k++) step(0, 0, '0, '0, 1, 1, 10'(16'h40 + k), 32'hA000_0000 + k, 0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) step(k % 2 == 0, 0, 10'(16'h40 + k), '0, k % 2 == 1, 0, 10'(16'h40 + k), '0, 0);
      else       idle(0);
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          chk("b2b_a_rvalid", o_arv, 1);
          chk("b2b_a_rdata", o_ard, 32'hA000_0000 + k - 1);
        end else begin
          chk("b2b_b_rvalid", o_brv, 1);
          chk("b2b_b_rdata", o_brd, 32'hA000_0000 + k - 1);
        end
      end
    end

    // reset mid-read
    step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
    @(negedge CLK);
    A_REQ = 0; B_REQ = 0; RST_N = 1'b0;
    #1;
    chk("midrst_a_rvalid", A_RVALID, 0);
    chk("midrst_a_gnt", A_GNT, 0);
    m_run = 0; m_starve = 0; m_own = 0;
    @(negedge CLK); RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 10'h011, '0, 0, 0, '0, '0, 0);
      chk("midrst_hold", o_agnt, 0);
    end
    step(1, 0, 10'h011, '0, 0, 0, '0, '0, 1);
    step(1, 0, 10'h011, '0, 0, 0, '0, '0, 0);
    chk("midrst_regrant", o_agnt, 1);

    // randomized traffic on a small address window
    pa = 0; pb = 0; paw = 0; pbw = 0; paa = '0; pba = '0; pad = '0; pbd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pa && $urandom_range(0, 2) == 0) begin
        pa = 1; paw = $urandom_range(0, 1); paa = 10'($urandom_range(0, 15)); pad = $urandom;
      end else if (pa && $urandom_range(0, 15) == 0) pa = 0;
      if (!pb && $urandom_range(0, 1) == 0) begin
        pb = 1; pbw = $urandom_range(0, 1); pba = 10'($urandom_range(0, 15)); pbd = $urandom;
      end else if (pb && $urandom_range(0, 15) == 0) pb = 0;
      step(pa, paw, paa, pad, pb, pbw, pba, pbd, 1);
      if (m_ega) pa = 0;
      if (m_egb) pb = 0;
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
